// File: rtl/mul_multicycle_pkg.sv
// Shared types and width helpers for the parametrised multicycle FP multiplier.
package mul_multicycle_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MULT  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } mul_state_t;

  typedef enum logic {
    RND_RNE   = 1'b0,
    RND_TRUNC = 1'b1
  } rnd_mode_t;

  function automatic int calc_w(input int exp_w, input int mant_w);
    return 32'sd1 + exp_w + mant_w;
  endfunction

  function automatic int calc_m(input int mant_w);
    return mant_w + 32'sd1;
  endfunction

  function automatic int calc_n(input int mant_w, input int bpc);
    return (mant_w + 32'sd1) / bpc;
  endfunction

  function automatic int calc_cnt_w(input int n);
    return (n > 32'sd1) ? $clog2(n) : 32'sd1;
  endfunction

endpackage

// File: rtl/mul_norm_round.sv
// Normalises the raw significand product, rounds it and resolves the special
// operand and exponent-range cases into a packed result plus status flags.
module mul_norm_round
  import mul_multicycle_pkg::*;
#(
  parameter int EXP_W  = 5,
  parameter int MANT_W = 7
) (
  input  logic [2*MANT_W+1:0]       prod,
  input  logic signed [EXP_W+1:0]   exp_in,
  input  logic                      sign,
  input  rnd_mode_t                 mode,
  input  logic                      op_zero,
  input  logic                      op_inf,
  output logic [EXP_W+MANT_W:0]     res,
  output logic                      ovf,
  output logic                      unf,
  output logic                      inexact
);
  localparam int M   = calc_m(MANT_W);
  localparam int EW2 = EXP_W + 2;
  localparam logic signed [EW2-1:0] EXP_MAX_S  = EW2'((32'sd2 ** EXP_W) - 32'sd1);
  localparam logic signed [EW2-1:0] EXP_ZERO_S = {EW2{1'b0}};
  localparam logic [MANT_W-1:0]     QNAN_FRAC  = MANT_W'(1'b1) << (MANT_W - 1);

  logic [2*M-1:0]          norm_s;
  logic signed [EW2-1:0]   exp_n_s;
  logic signed [EW2-1:0]   exp_f_s;
  logic [MANT_W-1:0]       frac_s;
  logic                    guard_s;
  logic                    sticky_s;
  logic                    inc_s;
  logic [MANT_W:0]         sum_s;

  // Normalise, round, then pick the result class
  always_comb begin
    norm_s   = prod[2*M-1] ? prod : {prod[2*M-2:0], 1'b0};
    exp_n_s  = exp_in + $signed({{(EW2-1){1'b0}}, prod[2*M-1]});
    frac_s   = norm_s[2*M-2:M];
    guard_s  = norm_s[M-1];
    sticky_s = |norm_s[M-2:0];
    inc_s    = (mode == RND_RNE) & guard_s & (sticky_s | frac_s[0]);
    // a carry leaves the fraction all-zero, so only the exponent moves
    sum_s    = {1'b0, frac_s} + {{MANT_W{1'b0}}, inc_s};
    exp_f_s  = exp_n_s + $signed({{(EW2-1){1'b0}}, sum_s[MANT_W]});
    res      = {(EXP_W+MANT_W+1){1'b0}};
    ovf      = 1'b0;
    unf      = 1'b0;
    inexact  = 1'b0;
    if (op_zero && op_inf) begin
      res = {1'b0, {EXP_W{1'b1}}, QNAN_FRAC};
    end else if (op_inf) begin
      res = {sign, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
    end else if (op_zero) begin
      res = {sign, {(EXP_W+MANT_W){1'b0}}};
    end else if (exp_f_s >= EXP_MAX_S) begin
      res     = {sign, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
      ovf     = 1'b1;
      inexact = 1'b1;
    end else if (exp_f_s <= EXP_ZERO_S) begin
      res     = {sign, {(EXP_W+MANT_W){1'b0}}};
      unf     = 1'b1;
      inexact = 1'b1;
    end else begin
      res     = {sign, exp_f_s[EXP_W-1:0], sum_s[MANT_W-1:0]};
      inexact = guard_s | sticky_s;
    end
  end

endmodule

// File: rtl/mul_multicycle_param.sv
// Iterative shift-add floating-point multiplier with busy/done handshake,
// abort via stop, and selectable rounding mode.
module mul_multicycle_param
  import mul_multicycle_pkg::*;
#(
  parameter int EXP_W          = 5,
  parameter int MANT_W         = 7,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                    clk,
  input  logic                    nRST,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    rnd_mode,
  input  logic [EXP_W+MANT_W:0]   op1,
  input  logic [EXP_W+MANT_W:0]   op2,
  output logic [EXP_W+MANT_W:0]   out,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow,
  output logic                    underflow,
  output logic                    round_loss
);
  localparam int W     = calc_w(EXP_W, MANT_W);
  localparam int M     = calc_m(MANT_W);
  localparam int N     = calc_n(MANT_W, BITS_PER_CYCLE);
  localparam int CNT_W = calc_cnt_w(N);
  localparam int EW2   = EXP_W + 2;
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(N - 32'sd1);
  localparam logic signed [EW2-1:0] BIAS_S   = EW2'((32'sd2 ** (EXP_W - 32'sd1)) - 32'sd1);

  mul_state_t             state_r, state_nxt_s;
  logic                   busy_r, done_r, busy_nxt_s, done_nxt_s;
  logic [CNT_W-1:0]       cnt_r;
  logic [2*M-1:0]         mcand_r, acc_r, step_s;
  logic [M-1:0]           mplier_r;
  logic                   sign_r, zero_r, inf_r;
  logic signed [EW2-1:0]  exp_r;
  rnd_mode_t              mode_r;
  logic [EXP_W-1:0]       e1_s, e2_s;
  logic [W-1:0]           res_s, out_r;
  logic                   ovf_s, unf_s, inexact_s;
  logic                   ovf_r, unf_r, inexact_r;

  assign e1_s = op1[W-2:MANT_W];
  assign e2_s = op2[W-2:MANT_W];

  // State and handshake output registers
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= busy_nxt_s;
      done_r  <= done_nxt_s;
    end
  end

  // Next-state decode; stop aborts an operation in flight
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    if (start) state_nxt_s = MULT; else state_nxt_s = IDLE;
      MULT: begin
        if (stop)                   state_nxt_s = IDLE;
        else if (cnt_r == CNT_LAST) state_nxt_s = ROUND;
        else                        state_nxt_s = MULT;
      end
      ROUND:   if (stop) state_nxt_s = IDLE; else state_nxt_s = DONE;
      DONE:    if (stop) state_nxt_s = IDLE; else state_nxt_s = DONE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Handshake outputs decoded from the upcoming state
  always_comb begin
    busy_nxt_s = 1'b0;
    done_nxt_s = 1'b0;
    case (state_nxt_s)
      MULT, ROUND: busy_nxt_s = 1'b1;
      DONE:        done_nxt_s = 1'b1;
      default: begin
        busy_nxt_s = 1'b0;
        done_nxt_s = 1'b0;
      end
    endcase
  end

  // One shift-add step over BITS_PER_CYCLE multiplier bits
  always_comb begin
    step_s = acc_r;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      step_s = step_s + ((mcand_r << i) & {(2*M){mplier_r[i]}});
    end
  end

  // Operand capture, iteration, and result registers
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      cnt_r     <= {CNT_W{1'b0}};
      mcand_r   <= {(2*M){1'b0}};
      mplier_r  <= {M{1'b0}};
      acc_r     <= {(2*M){1'b0}};
      sign_r    <= 1'b0;
      zero_r    <= 1'b0;
      inf_r     <= 1'b0;
      exp_r     <= {EW2{1'b0}};
      mode_r    <= RND_RNE;
      out_r     <= {W{1'b0}};
      ovf_r     <= 1'b0;
      unf_r     <= 1'b0;
      inexact_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            cnt_r    <= {CNT_W{1'b0}};
            mcand_r  <= {{M{1'b0}}, 1'b1, op1[MANT_W-1:0]};
            mplier_r <= {1'b1, op2[MANT_W-1:0]};
            acc_r    <= {(2*M){1'b0}};
            sign_r   <= op1[W-1] ^ op2[W-1];
            zero_r   <= (e1_s == {EXP_W{1'b0}}) | (e2_s == {EXP_W{1'b0}});
            inf_r    <= (&e1_s) | (&e2_s);
            exp_r    <= $signed({2'b00, e1_s}) + $signed({2'b00, e2_s}) - BIAS_S;
            mode_r   <= rnd_mode_t'(rnd_mode);
          end
        end
        MULT: begin
          acc_r    <= step_s;
          mcand_r  <= mcand_r << BITS_PER_CYCLE;
          mplier_r <= mplier_r >> BITS_PER_CYCLE;
          cnt_r    <= cnt_r + CNT_W'(1'b1);
        end
        ROUND: begin
          if (!stop) begin
            out_r     <= res_s;
            ovf_r     <= ovf_s;
            unf_r     <= unf_s;
            inexact_r <= inexact_s;
          end
        end
        default: begin
        end
      endcase
    end
  end

  mul_norm_round #(
    .EXP_W  (EXP_W),
    .MANT_W (MANT_W)
  ) u_norm_round (
    .prod    (acc_r),
    .exp_in  (exp_r),
    .sign    (sign_r),
    .mode    (mode_r),
    .op_zero (zero_r),
    .op_inf  (inf_r),
    .res     (res_s),
    .ovf     (ovf_s),
    .unf     (unf_s),
    .inexact (inexact_s)
  );

  assign out        = out_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign overflow   = ovf_r;
  assign underflow  = unf_r;
  assign round_loss = inexact_r;

endmodule

// File: tb/tb_mul_multicycle_param.sv
// Directed bench: three multiplier instances (1, 2 and 4 bits per cycle) share
// stimulus; results, handshake timing, abort and reset are checked by assertion.
module tb_mul_multicycle_param;

  logic               tb_clk = 1'b0;
  logic               nRST, start, stop, rnd_mode;
  logic [12:0]        op1, op2;
  logic [2:0][12:0]   out_v;
  logic [2:0]         busy_v, done_v, ovf_v, unf_v, rl_v;
  logic [2:0][12:0]   prior_out;
  logic [2:0][2:0]    prior_flags;
  int                 n_checks = 0;
  int                 n_fail   = 0;
  int                 lat [3]  = '{9, 5, 3};

  always #5 tb_clk = ~tb_clk;

  mul_multicycle_param #(.EXP_W(5), .MANT_W(7), .BITS_PER_CYCLE(1)) u_dut1 (
    .clk(tb_clk), .nRST(nRST), .start(start), .stop(stop), .rnd_mode(rnd_mode),
    .op1(op1), .op2(op2), .out(out_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .overflow(ovf_v[0]), .underflow(unf_v[0]), .round_loss(rl_v[0]));

  mul_multicycle_param #(.EXP_W(5), .MANT_W(7), .BITS_PER_CYCLE(2)) u_dut2 (
    .clk(tb_clk), .nRST(nRST), .start(start), .stop(stop), .rnd_mode(rnd_mode),
    .op1(op1), .op2(op2), .out(out_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .overflow(ovf_v[1]), .underflow(unf_v[1]), .round_loss(rl_v[1]));

  mul_multicycle_param #(.EXP_W(5), .MANT_W(7), .BITS_PER_CYCLE(4)) u_dut4 (
    .clk(tb_clk), .nRST(nRST), .start(start), .stop(stop), .rnd_mode(rnd_mode),
    .op1(op1), .op2(op2), .out(out_v[2]), .busy(busy_v[2]), .done(done_v[2]),
    .overflow(ovf_v[2]), .underflow(unf_v[2]), .round_loss(rl_v[2]));

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s [dut%0d]: observed %0h expected %0h", tag, k, obs, expv);
    end
  endtask

  // {overflow, underflow, round_loss} per instance, compared to the model
  task automatic chk_results(input string tag);
    for (int k = 0; k < 3; k++) begin
      chk({tag, "_out"}, k, 32'(out_v[k]), 32'(prior_out[k]));
      chk({tag, "_flags"}, k, 32'({ovf_v[k], unf_v[k], rl_v[k]}), 32'(prior_flags[k]));
    end
  endtask

  task automatic run_op(input string tag, input logic [12:0] a, input logic [12:0] b,
                        input logic m, input logic restart, input int abort_at,
                        input logic [12:0] exp_out, input logic [2:0] exp_flags);
    logic aborted;
    @(negedge tb_clk);
    op1 = a; op2 = b; rnd_mode = m; start = 1'b1;
    @(negedge tb_clk);
    start = 1'b0;
    for (int j = 0; j < 10; j++) begin
      aborted = (abort_at >= 0) && (j > abort_at);
      for (int k = 0; k < 3; k++) begin
        chk({tag, "_busy"}, k, 32'(busy_v[k]), 32'(!aborted && (j < lat[k])));
        chk({tag, "_done"}, k, 32'(done_v[k]), 32'(!aborted && (j >= lat[k])));
      end
      if (restart && j == 2) begin
        start = 1'b1; op1 = 13'h0840;
      end else if (restart && j == 3) begin
        start = 1'b0; op1 = a;
      end
      if (j == abort_at) stop = 1'b1;
      if (j == abort_at + 1) stop = 1'b0;
      @(negedge tb_clk);
    end
    for (int k = 0; k < 3; k++) begin
      if (abort_at < 0 || lat[k] <= abort_at) begin
        prior_out[k]   = exp_out;
        prior_flags[k] = exp_flags;
      end
    end
    chk_results(tag);
  endtask

  task automatic release_dut(input int hold);
    for (int h = 0; h < hold; h++) begin
      chk("done_hold", 0, 32'(done_v[0]), 32'd1);
      @(negedge tb_clk);
    end
    stop = 1'b1;
    @(negedge tb_clk);
    stop = 1'b0;
    for (int k = 0; k < 3; k++) chk("done_drop", k, 32'(done_v[k]), 32'd0);
  endtask

  initial begin
    nRST = 1'b1; start = 1'b0; stop = 1'b0; rnd_mode = 1'b0;
    op1 = 13'h0000; op2 = 13'h0000;
    prior_out = '0; prior_flags = '0;
    #2 nRST = 1'b0;
    @(negedge tb_clk);
    @(negedge tb_clk);
    for (int k = 0; k < 3; k++) begin
      chk("rst_busy", k, 32'(busy_v[k]), 32'd0);
      chk("rst_done", k, 32'(done_v[k]), 32'd0);
    end
    chk_results("rst");
    nRST = 1'b1;

    run_op("m1p5sq", 13'h07C0, 13'h07C0, 1'b0, 1'b0, -1, 13'h0810, 3'b000);
    release_dut(5);
    run_op("neg3", 13'h1780, 13'h0840, 1'b0, 1'b0, -1, 13'h1840, 3'b000);
    release_dut(0);
    run_op("lsbsq", 13'h0781, 13'h0781, 1'b0, 1'b0, -1, 13'h0782, 3'b001);
    release_dut(0);
    run_op("tie_rne", 13'h0781, 13'h07C0, 1'b0, 1'b0, -1, 13'h07C2, 3'b001);
    release_dut(0);
    run_op("tie_trunc", 13'h0781, 13'h07C0, 1'b1, 1'b0, -1, 13'h07C1, 3'b001);
    release_dut(0);
    run_op("restart", 13'h07C0, 13'h07C0, 1'b0, 1'b1, -1, 13'h0810, 3'b000);
    release_dut(0);
    run_op("abort", 13'h1780, 13'h0840, 1'b0, 1'b0, 3, 13'h1840, 3'b000);
    release_dut(0);
    run_op("underflow", 13'h0080, 13'h0080, 1'b0, 1'b0, -1, 13'h0000, 3'b011);
    release_dut(0);
    run_op("nan", 13'h0F80, 13'h0000, 1'b0, 1'b0, -1, 13'h0FC0, 3'b000);
    release_dut(0);
    run_op("overflow", 13'h0F00, 13'h0F00, 1'b0, 1'b0, -1, 13'h0F80, 3'b101);
    release_dut(0);

    // asynchronous reset in the middle of an operation
    @(negedge tb_clk);
    op1 = 13'h07C0; op2 = 13'h07C0; rnd_mode = 1'b0; start = 1'b1;
    @(negedge tb_clk);
    start = 1'b0;
    @(negedge tb_clk);
    @(negedge tb_clk);
    nRST = 1'b0;
    #1;
    prior_out = '0; prior_flags = '0;
    for (int k = 0; k < 3; k++) begin
      chk("midrst_busy", k, 32'(busy_v[k]), 32'd0);
      chk("midrst_done", k, 32'(done_v[k]), 32'd0);
    end
    chk_results("midrst");
    @(negedge tb_clk);
    nRST = 1'b1;
    run_op("after_rst", 13'h07C0, 13'h07C0, 1'b0, 1'b0, -1, 13'h0810, 3'b000);
    release_dut(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
